hazard_stall_controller: RTL and testbench

- Pipeline hazard sequencer for the 5-stage core. It generates PC/IF-ID write enables, IF/ID flush, ID/EX bubble insertion and full-pipe freeze.
- Resolves four conditions: load-use hazards, hazards against an in-flight multi-cycle mul/div result (1-entry scoreboard), branch mispredict flushes and data-memory busy freezes.
- Sits beside the forwarding logic, which still handles all EX/MEM and MEM/WB bypasses. This block only covers cases forwarding cannot resolve.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_stall_controller.sv | 106 ++++++++++
 tb/tb_hazard_stall_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use and mul/div scoreboard stalls, mispredict
// flushes, memory-busy freezes, plus a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_muldiv,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mispredict,
  input  logic             md_done,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             md_issue,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             md_state_dbg
);

  // md_issue/md_done form a single-entry issue/retire pair: md_issue is only
  // raised from MD_IDLE, and md_done is honoured only while MD_BUSY.
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

  md_state_t        state_q, state_d;
  logic [REG_W-1:0] md_rd_q;
  logic [CNT_W-1:0] stall_q;

  logic load_use;
  logic sb_raw, sb_waw, sb_hazard;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // x0 as the pending destination never blocks readers or writers.
  assign sb_raw    = (md_rd_q != '0) &&
                     ((id_use_rs1 && (id_rs1 == md_rd_q)) ||
                      (id_use_rs2 && (id_rs2 == md_rd_q)));
  assign sb_waw    = (md_rd_q != '0) && id_reg_write && (id_rd == md_rd_q);
  assign sb_hazard = (state_q == MD_BUSY) && (sb_raw || sb_waw || id_is_muldiv);

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    md_issue     = 1'b0;
    state_d      = state_q;
    if (reset_n) begin
      if (mem_busy) begin
        pipe_hold = 1'b1;
      end else if (ex_mispredict) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use || sb_hazard) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        md_issue    = id_is_muldiv;
      end
      // Retirement is independent of the priority case; flushes never cancel it.
      if ((state_q == MD_BUSY) && md_done) begin
        state_d = MD_IDLE;
      end else if (md_issue) begin
        state_d = MD_BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      md_rd_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (md_issue) begin
        md_rd_q <= id_rd;
      end
      if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign md_busy      = (state_q == MD_BUSY);
  assign md_state_dbg = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, directed multi-cycle
// sequences and a randomized run checked against a rule-level model.
module tb_hazard_stall_controller;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd, ex_rd;
  logic             id_use_rs1, id_use_rs2, id_reg_write, id_is_muldiv;
  logic             ex_mem_read, ex_mispredict, md_done, mem_busy;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
  logic             md_issue, md_busy, md_state_dbg;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  bit pend;
  int prd;
  int cnt;

  hazard_stall_controller #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_muldiv(id_is_muldiv),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
    .md_done(md_done), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .md_issue(md_issue),
    .md_busy(md_busy), .stall_cycles(stall_cycles), .md_state_dbg(md_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, md_issue};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_is_muldiv = 0;
    ex_mem_read = 0; ex_mispredict = 0; md_done = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    pend = 0; prd = 0; cnt = 0;
  endtask

  // inputs are set just after an edge; sample mid-cycle, then advance
  task automatic cyc_check(string nm, logic [5:0] e, logic eb, int ec);
    #2;
    check({nm, ".outs"}, 32'(outs()), 32'(e));
    check({nm, ".busy"}, 32'(md_busy), 32'(eb));
    check({nm, ".cnt"}, 32'(stall_cycles), 32'(ec));
    @(posedge clk);
    #1;
  endtask

  // rule-level reference: which priority case applies, and its outputs
  function automatic bit reads(int r);
    return (id_use_rs1 && int'(id_rs1) == r) || (id_use_rs2 && int'(id_rs2) == r);
  endfunction

  function automatic logic [5:0] model_out();
    bit lu, sb;
    lu = ex_mem_read && ex_rd != 0 && reads(int'(ex_rd));
    sb = pend && ((prd != 0 && (reads(prd) || (id_reg_write && int'(id_rd) == prd)))
                  || id_is_muldiv);
    if (mem_busy)       return 6'b000010;
    if (ex_mispredict)  return 6'b111100;
    if (lu || sb)       return 6'b000100;
    return {5'b11000, id_is_muldiv};
  endfunction

  typedef struct {
    logic       mb, mp, mr;
    logic [4:0] exr, r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, md;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    clear_inputs();
    // mb mp mr exr r1 u1 r2 u2 rd rw md exp
    vt[0] = '{0,0,0, 0, 0,0, 0,0, 0,0,0, 6'b110000};
    vt[1] = '{0,0,1, 5, 0,0, 5,1, 6,1,0, 6'b000100};
    vt[2] = '{0,0,1, 0, 0,1, 0,1, 6,1,0, 6'b110000};
    vt[3] = '{0,0,1, 5, 5,0, 2,1, 6,1,0, 6'b110000};
    vt[4] = '{1,1,0, 0, 0,0, 0,0, 0,0,0, 6'b000010};
    vt[5] = '{0,1,1, 5, 5,1, 0,0, 9,1,1, 6'b111100};
    vt[6] = '{1,0,1, 5, 5,1, 0,0, 0,0,0, 6'b000010};
    vt[7] = '{0,0,1, 3, 3,1, 0,0, 4,1,1, 6'b000100};
    vt[8] = '{0,0,0, 0, 0,0, 0,0, 7,1,1, 6'b110001};

    // reset state: every output 0 while reset_n is low, even with hazards asserted
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_is_muldiv = 1;
    #3;
    check("reset.outs", 32'(outs()), 32'd0);
    check("reset.busy", 32'(md_busy), 32'd0);
    check("reset.cnt", 32'(stall_cycles), 32'd0);
    do_reset();

    // vector table (state stays idle until the issuing entry, which is last)
    for (int i = 0; i < 9; i++) begin
      mem_busy = vt[i].mb; ex_mispredict = vt[i].mp; ex_mem_read = vt[i].mr;
      ex_rd = vt[i].exr; id_rs1 = vt[i].r1; id_use_rs1 = vt[i].u1;
      id_rs2 = vt[i].r2; id_use_rs2 = vt[i].u2; id_rd = vt[i].rd;
      id_reg_write = vt[i].rw; id_is_muldiv = vt[i].md;
      #2;
      check($sformatf("vec%0d.outs", i), 32'(outs()), 32'(vt[i].exp));
      check($sformatf("vec%0d.busy", i), 32'(md_busy), 32'd0);
      @(posedge clk);
      #1;
    end

    // load-use: one stall cycle
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    cyc_check("lu.stall", 6'b000100, 0, 0);
    ex_mem_read = 0;
    cyc_check("lu.run", 6'b110000, 0, 1);
    clear_inputs();
    cyc_check("lu.after", 6'b110000, 0, 1);

    // mul x7 then dependent add; md_done in third stall cycle
    do_reset();
    id_is_muldiv = 1; id_rd = 7; id_reg_write = 1;
    cyc_check("md.issue", 6'b110001, 0, 0);
    id_is_muldiv = 0; id_rd = 8; id_rs1 = 7; id_use_rs1 = 1;
    cyc_check("md.dep1", 6'b000100, 1, 0);
    cyc_check("md.dep2", 6'b000100, 1, 1);
    md_done = 1;
    cyc_check("md.dep3", 6'b000100, 1, 2);
    md_done = 0;
    cyc_check("md.go", 6'b110000, 0, 3);

    // freeze holds a mispredict for 4 cycles, then flush
    do_reset();
    ex_mispredict = 1; mem_busy = 1;
    for (int i = 0; i < 4; i++) cyc_check($sformatf("frz%0d", i), 6'b000010, 0, i);
    mem_busy = 0;
    cyc_check("frz.flush", 6'b111100, 0, 4);
    clear_inputs();
    cyc_check("frz.after", 6'b110000, 0, 4);

    // flush wins over load-use and a mul/div in ID
    do_reset();
    ex_mispredict = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    id_is_muldiv = 1; id_rd = 6; id_reg_write = 1;
    cyc_check("fl.prio", 6'b111100, 0, 0);
    clear_inputs();
    cyc_check("fl.nobusy", 6'b110000, 0, 0);

    // WAW, structural, and retirement during freeze
    do_reset();
    id_is_muldiv = 1; id_rd = 4; id_reg_write = 1;
    cyc_check("sb.issue", 6'b110001, 0, 0);
    id_is_muldiv = 0;
    cyc_check("sb.waw", 6'b000100, 1, 0);
    id_is_muldiv = 1; id_rd = 9;
    cyc_check("sb.struct", 6'b000100, 1, 1);
    clear_inputs(); mem_busy = 1; md_done = 1;
    cyc_check("sb.frzdone", 6'b000010, 1, 2);
    clear_inputs(); id_rs1 = 4; id_use_rs1 = 1;
    cyc_check("sb.free", 6'b110000, 0, 3);

    // pending destination x0 never blocks
    do_reset();
    id_is_muldiv = 1; id_rd = 0; id_reg_write = 1;
    cyc_check("x0.issue", 6'b110001, 0, 0);
    id_is_muldiv = 0; id_rs1 = 0; id_use_rs1 = 1;
    cyc_check("x0.read", 6'b110000, 1, 0);

    // asynchronous reset while MD_BUSY with 9 stall cycles counted
    do_reset();
    id_is_muldiv = 1; id_rd = 7; id_reg_write = 1;
    cyc_check("rst.issue", 6'b110001, 0, 0);
    id_is_muldiv = 0; id_rd = 8; id_rs1 = 7; id_use_rs1 = 1;
    for (int i = 0; i < 9; i++) cyc_check($sformatf("rst.dep%0d", i), 6'b000100, 1, i);
    #2;
    check("rst.pre_cnt", 32'(stall_cycles), 32'd9);
    reset_n = 1'b0;
    #1;
    check("rst.outs", 32'(outs()), 32'd0);
    check("rst.busy", 32'(md_busy), 32'd0);
    check("rst.cnt", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc_check("rst.dep_free", 6'b110000, 0, 0);

    // counter saturation
    do_reset();
    mem_busy = 1;
    for (int i = 0; i < CNT_MAX + 3; i++)
      cyc_check($sformatf("sat%0d", i), 6'b000010, 0, (i < CNT_MAX) ? i : CNT_MAX);

    // randomized run against the reference model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [5:0] e;
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));
      id_is_muldiv = ($urandom_range(0, 2) == 0);
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_mispredict = ($urandom_range(0, 5) == 0);
      md_done = ($urandom_range(0, 3) == 0);
      mem_busy = ($urandom_range(0, 6) == 0);
      #2;
      e = model_out();
      check("rnd.outs", 32'(outs()), 32'(e));
      check("rnd.busy", 32'(md_busy), 32'(pend));
      check("rnd.cnt", 32'(stall_cycles), 32'(cnt));
      @(posedge clk);
      if (pend && md_done) pend = 0;
      else if (e[0]) begin pend = 1; prd = int'(id_rd); end
      if (!e[5] && cnt < CNT_MAX) cnt++;
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
